key_calc: RTL and testbench
===========================

# key_calc

Key-event decoder and integer calculator sitting directly downstream of the 4x4 keypad scanner. Consumes the scanner's held key code and key-present flag, turns each new press into a single event, accumulates decimal operands, and evaluates left-to-right `+`/`-` chains on `=`. Emits the signed result for display, and an ASCII echo byte per accepted key for the serial transmitter.

## Interface
- `WIDTH`, 16: result/operand width, two's complement.
- `MAX_DIGITS`, 4: maximum digits per operand. Further digits are ignored.

- `IN_clk` in 1: single clock, shared with the scanner.
- `IN_reset` in 1: synchronous, active-high reset.
- `IN_value` in 4: key code from the scanner.
  - 0-9 are digits.
  - 10 is `+`, 11 is `-`, 15 is `=`, 14 is clear.
  - 12 and 13 are ignored.
- `IN_key` in 1: key-present flag from the scanner. Stays high for several clocks after release.
- `IN_tx_ready` in 1: serial transmitter accepts `OUT_tx_data` this cycle.
- `OUT_entry` out WIDTH: operand currently being typed (unsigned magnitude).
- `OUT_result` out WIDTH: last evaluated result (signed).
- `OUT_result_valid` out 1: one-cycle pulse when `OUT_result` updates.
- `OUT_overflow` out 1: sticky flag, set when any add or subtract overflowed signed WIDTH.
- `OUT_tx_data` out 8: ASCII echo byte.
- `OUT_tx_valid` out 1: echo byte pending.

## Operation
- **Reset values:** `OUT_entry`=0, `OUT_result`=0, `OUT_result_valid`=0, `OUT_overflow`=0, `OUT_tx_data`=0x00, `OUT_tx_valid`=0. Internal state: accumulator=0, pending op=`+`, digit count=0, state IDLE.
- **Key event:** fires when either condition holds:
  - `IN_key` is high and was low on the previous clock, or
  - `IN_key` is high and `IN_value` differs from the last accepted code (roll-over).
- A held key produces exactly one event.
- **FSM states:** IDLE, DIGIT, OP, RESULT.
- **Digit event:**
  - From IDLE, OP or DIGIT: `entry = entry*10 + d` if digit count < MAX_DIGITS, otherwise the key is ignored and not echoed. Next state is DIGIT.
  - From RESULT: start a fresh calculation. Set accumulator=0, op=`+`, overflow=0, entry=d. Next state is DIGIT.
  - Compute `*10` as `(e<<3)+(e<<1)`.
- **Operator event (`+`/`-`):**
  - From DIGIT: accumulator = accumulator op entry; entry=0; store the new op; next state OP.
  - From OP: replace the pending op only.
  - From RESULT: accumulator = `OUT_result` (chaining); store the op; next state OP.
  - From IDLE: accumulator stays 0; next state OP.
- **Equals event:**
  - Result = accumulator op entry (entry is 0 if no digits were typed).
  - Load `OUT_result`, pulse `OUT_result_valid`, set accumulator = result, clear entry, go to RESULT.
  - `=` in RESULT re-outputs the same value and pulses again.
- **Clear event:** return to reset values in all state. Any pending echo is replaced by 'C'.
- **Arithmetic:** wraps modulo 2^WIDTH. Overflow is detected from operand and result sign bits and sets `OUT_overflow`, which holds until clear, reset or a fresh calculation.
- **Echo:** each accepted key loads a one-entry buffer with its ASCII byte:
  - '0'-'9' → 0x30-0x39
  - '+' → 0x2B, '-' → 0x2D, '=' → 0x3D, clear → 0x43
- **Echo handshake:**
  - `OUT_tx_valid` stays high and `OUT_tx_data` stays stable until a cycle with `IN_tx_ready`=1. The buffer empties on that edge.
  - A new event arriving while the buffer is full is still processed, but its echo is dropped; the pending byte is kept.
  - The exception is clear, which always overwrites the pending byte.
  - An event and acceptance in the same cycle load the new byte.

## Timing
- Event sampled at edge k. `OUT_entry`, `OUT_result`, `OUT_result_valid` and `OUT_tx_valid` all update at edge k, visible in cycle k+1. Latency is one clock.
- `OUT_result_valid` is high for exactly one cycle per `=`.
- Reset asserted mid-entry or with an echo pending takes effect at the next edge and discards all pending state.

## Structure
- Package `key_pkg` holds:
  - key code constants (KEY_PLUS=10, KEY_MINUS=11, KEY_CLR=14, KEY_EQ=15);
  - ASCII constants;
  - the FSM state encoding.
- Sub-module `key_event`: edge/roll-over detector that outputs a one-cycle `event` pulse plus the latched code. `key_calc` instantiates it.

## Test plan
- Keys 1,2,+,3,4,= (each held 6 clocks, gaps of 4) → `OUT_result`=46, single valid pulse; echo "12+34=" when `IN_tx_ready` is tied high.
- 5,-,9,= → `OUT_result`=-4 (0xFFFC); then +,1,= → -3, exercising chaining from RESULT.
- Digits 1,2,3,4,5 → `OUT_entry`=1234; the fifth digit is not echoed.
- 9,9,9,9,+ repeated 4 times, then = with WIDTH=16 → result 39996 wraps to -25540, `OUT_overflow`=1; a subsequent digit clears it.
- `IN_tx_ready`=0, keys 1,2 → `OUT_tx_data`=0x31 held and '2' dropped; then clear → 0x43; raising ready for one cycle drops `OUT_tx_valid`.
- Reset pulse while `OUT_entry`=12 → all outputs 0 on the next cycle; a single key held 20 clocks → one event only.

Source files
------------

// File: rtl/key_pkg.sv
// Shared key codes, ASCII echo bytes and state encodings for the keypad calculator.
package key_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'd10;
  localparam logic [3:0] KEY_MINUS = 4'd11;
  localparam logic [3:0] KEY_CLR   = 4'd14;
  localparam logic [3:0] KEY_EQ    = 4'd15;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_CLR   = 8'h43;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIGIT,
    ST_OP,
    ST_RESULT
  } state_t;

  typedef enum logic {
    OP_ADD,
    OP_SUB
  } op_t;

  // Only meaningful for codes the calculator accepts (digits, +, -, =, clear).
  function automatic logic [7:0] key_ascii(input logic [3:0] code);
    case (code)
      KEY_PLUS:  return ASCII_PLUS;
      KEY_MINUS: return ASCII_MINUS;
      KEY_EQ:    return ASCII_EQ;
      KEY_CLR:   return ASCII_CLR;
      default:   return ASCII_ZERO + {4'h0, code};
    endcase
  endfunction

endpackage

// File: rtl/key_event.sv
// Turns the scanner's held key-present flag into one event per press or roll-over.
module key_event (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic [3:0] value,
  output logic       evt,
  output logic [3:0] code
);

  logic       key_p1;
  logic [3:0] last_code;

  // Combinational so the calculator can act on the event at the same edge.
  assign evt  = key && (!key_p1 || (value != last_code));
  assign code = value;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_p1    <= 1'b0;
      last_code <= 4'd0;
    end else begin
      key_p1 <= key;
      if (evt) last_code <= value;
    end
  end

endmodule

// File: rtl/key_calc.sv
// Keypad event decoder and left-to-right +/- integer calculator with ASCII echo.
module key_calc
  import key_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic                    IN_clk,
  input  logic                    IN_reset,
  input  logic [3:0]              IN_value,
  input  logic                    IN_key,
  input  logic                    IN_tx_ready,
  output logic [WIDTH-1:0]        OUT_entry,
  output logic signed [WIDTH-1:0] OUT_result,
  output logic                    OUT_result_valid,
  output logic                    OUT_overflow,
  output logic [7:0]              OUT_tx_data,
  output logic                    OUT_tx_valid
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic                    evt;
  logic [3:0]              code;
  state_t                  state;
  op_t                     op;
  op_t                     new_op;
  logic signed [WIDTH-1:0] acc;
  logic [CNT_W-1:0]        digits;
  logic                    is_digit;
  logic                    is_op;
  logic                    digit_ok;
  logic                    accepted;
  logic                    alu_ovf;
  logic signed [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0]        entry_next;

  function automatic logic [WIDTH-1:0] times10(input logic [WIDTH-1:0] e);
    return (e << 3) + (e << 1);
  endfunction

  // Wrapping add/subtract; MSB of the return value flags signed overflow.
  function automatic logic [WIDTH:0] arith(input logic signed [WIDTH-1:0] a,
                                           input logic signed [WIDTH-1:0] b,
                                           input op_t                     o);
    logic signed [WIDTH-1:0] r;
    logic                    v;
    if (o == OP_SUB) begin
      r = a - b;
      v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else begin
      r = a + b;
      v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return {v, r};
  endfunction

  key_event u_event (
    .clk   (IN_clk),
    .rst   (IN_reset),
    .key   (IN_key),
    .value (IN_value),
    .evt   (evt),
    .code  (code)
  );

  always_comb begin
    is_digit   = (code < 4'd10);
    is_op      = (code == KEY_PLUS) || (code == KEY_MINUS);
    new_op     = (code == KEY_MINUS) ? OP_SUB : OP_ADD;
    digit_ok   = is_digit && ((state == ST_RESULT) || (int'(digits) < MAX_DIGITS));
    accepted   = evt && (digit_ok || is_op || (code == KEY_EQ));
    {alu_ovf, alu_res} = arith(acc, $signed(OUT_entry), op);
    entry_next = times10(OUT_entry) + {{(WIDTH-4){1'b0}}, code};
  end

  // Event decode, calculator state and echo buffer all update on the event edge.
  always_ff @(posedge IN_clk) begin
    if (IN_reset) begin
      state            <= ST_IDLE;
      op               <= OP_ADD;
      acc              <= '0;
      digits           <= '0;
      OUT_entry        <= '0;
      OUT_result       <= '0;
      OUT_result_valid <= 1'b0;
      OUT_overflow     <= 1'b0;
      OUT_tx_data      <= 8'h00;
      OUT_tx_valid     <= 1'b0;
    end else begin
      OUT_result_valid <= 1'b0;
      if (OUT_tx_valid && IN_tx_ready) OUT_tx_valid <= 1'b0;

      if (evt && (code == KEY_CLR)) begin
        state        <= ST_IDLE;
        op           <= OP_ADD;
        acc          <= '0;
        digits       <= '0;
        OUT_entry    <= '0;
        OUT_result   <= '0;
        OUT_overflow <= 1'b0;
        OUT_tx_data  <= ASCII_CLR;
        OUT_tx_valid <= 1'b1;
      end else if (evt) begin
        // A full buffer keeps its byte unless it is being drained this cycle.
        if (accepted && (!OUT_tx_valid || IN_tx_ready)) begin
          OUT_tx_data  <= key_ascii(code);
          OUT_tx_valid <= 1'b1;
        end

        if (is_digit) begin
          if (state == ST_RESULT) begin
            acc          <= '0;
            op           <= OP_ADD;
            OUT_overflow <= 1'b0;
            OUT_entry    <= {{(WIDTH-4){1'b0}}, code};
            digits       <= CNT_W'(1);
            state        <= ST_DIGIT;
          end else if (digit_ok) begin
            OUT_entry <= entry_next;
            digits    <= digits + CNT_W'(1);
            state     <= ST_DIGIT;
          end
        end else if (is_op) begin
          op    <= new_op;
          state <= ST_OP;
          if (state == ST_DIGIT) begin
            acc       <= alu_res;
            OUT_entry <= '0;
            digits    <= '0;
            if (alu_ovf) OUT_overflow <= 1'b1;
          end else if (state == ST_RESULT) begin
            acc <= OUT_result;
          end
        end else if (code == KEY_EQ) begin
          OUT_result       <= alu_res;
          OUT_result_valid <= 1'b1;
          acc              <= alu_res;
          OUT_entry        <= '0;
          digits           <= '0;
          state            <= ST_RESULT;
          if (alu_ovf) OUT_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_calc.sv
// Bench for key_calc: directed scenarios plus randomized key streams against an integer model.
module tb_key_calc;

  logic        clk = 1'b0;
  logic        reset;
  logic        key;
  logic [3:0]  value;
  logic        tx_ready;
  logic [15:0] entry;
  logic signed [15:0] result;
  logic        result_valid;
  logic        overflow;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  logic [7:0] echo_q[$];

  // Behavioural model state (plain integers, decimal semantics)
  bit         m_prev_key;
  logic [3:0] m_last_code;
  int         m_acc, m_entry, m_ndig, m_op, m_result;
  byte        m_mode;
  bit         m_valid, m_ovf, m_txv;
  logic [7:0] m_txd;

  always #5 clk = ~clk;

  key_calc #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .IN_clk           (clk),
    .IN_reset         (reset),
    .IN_value         (value),
    .IN_key           (key),
    .IN_tx_ready      (tx_ready),
    .OUT_entry        (entry),
    .OUT_result       (result),
    .OUT_result_valid (result_valid),
    .OUT_overflow     (overflow),
    .OUT_tx_data      (tx_data),
    .OUT_tx_valid     (tx_valid)
  );

  function automatic int wrap16(input int v);
    int r;
    r = v % 65536;
    if (r < 0) r += 65536;
    if (r >= 32768) r -= 65536;
    return r;
  endfunction

  task automatic model_reset();
    m_prev_key = 0; m_last_code = 4'd0;
    m_acc = 0; m_entry = 0; m_ndig = 0; m_op = 1; m_result = 0;
    m_mode = "I"; m_valid = 0; m_ovf = 0; m_txv = 0; m_txd = 8'h00;
  endtask

  task automatic model_edge();
    bit ev, room, echo;
    int full;
    logic [7:0] ch;
    if (reset) begin
      model_reset();
      return;
    end
    ev = key && (!m_prev_key || value != m_last_code);
    m_prev_key = key;
    if (ev) m_last_code = value;
    room = !m_txv || tx_ready;
    if (m_txv && tx_ready) m_txv = 0;
    m_valid = 0;
    if (!ev) return;
    if (value == 4'd14) begin
      m_acc = 0; m_entry = 0; m_ndig = 0; m_op = 1; m_result = 0;
      m_mode = "I"; m_ovf = 0; m_txd = 8'h43; m_txv = 1;
      return;
    end
    echo = 0;
    ch = 8'h00;
    if (value <= 4'd9) begin
      ch = 8'h30 + {4'h0, value};
      if (m_mode == "R") begin
        m_acc = 0; m_op = 1; m_ovf = 0; m_entry = value; m_ndig = 1;
        m_mode = "D"; echo = 1;
      end else if (m_ndig < 4) begin
        m_entry = m_entry * 10 + value; m_ndig++; m_mode = "D"; echo = 1;
      end
    end else if (value == 4'd10 || value == 4'd11) begin
      ch = (value == 4'd10) ? 8'h2B : 8'h2D;
      echo = 1;
      if (m_mode == "D") begin
        full = m_acc + m_op * m_entry;
        if (full > 32767 || full < -32768) m_ovf = 1;
        m_acc = wrap16(full); m_entry = 0; m_ndig = 0;
      end else if (m_mode == "R") begin
        m_acc = m_result;
      end
      m_op = (value == 4'd10) ? 1 : -1;
      m_mode = "O";
    end else if (value == 4'd15) begin
      ch = 8'h3D;
      echo = 1;
      full = m_acc + m_op * m_entry;
      if (full > 32767 || full < -32768) m_ovf = 1;
      m_result = wrap16(full); m_acc = m_result; m_valid = 1;
      m_entry = 0; m_ndig = 0; m_mode = "R";
    end
    if (echo && room) begin
      m_txd = ch; m_txv = 1;
    end
  endtask

  // One clock: model sees the same inputs as the DUT; echo bytes captured on handshake.
  task automatic cycle();
    model_edge();
    if (tx_valid && tx_ready) echo_q.push_back(tx_data);
    @(posedge clk);
    #1;
    if (result_valid) pulses++;
  endtask

  task automatic press(input logic [3:0] c);
    key = 1'b1; value = c;
    repeat (6) cycle();
    key = 1'b0;
    repeat (4) cycle();
  endtask

  function automatic string echo_str();
    string s = "";
    foreach (echo_q[i]) s = $sformatf("%s%c", s, echo_q[i]);
    return s;
  endfunction

  task automatic test_reset();
    reset = 1'b1; key = 1'b0; value = 4'd0; tx_ready = 1'b0;
    repeat (3) cycle();
    tests++;
    if ({entry, result, result_valid, overflow} !== 34'd0) begin
      fails++;
      $display("FAIL reset_calc: entry=%0d result=%0d valid=%b ovf=%b, required all 0",
               entry, result, result_valid, overflow);
    end
    tests++;
    if ({tx_data, tx_valid} !== 9'd0) begin
      fails++;
      $display("FAIL reset_echo: tx_data=%h tx_valid=%b, required 00/0", tx_data, tx_valid);
    end
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_add_chain();
    string got;
    tx_ready = 1'b1; echo_q.delete(); pulses = 0;
    press(4'd1); press(4'd2); press(4'd10); press(4'd3); press(4'd4); press(4'd15);
    tests++;
    if (result !== 16'sd46) begin
      fails++; $display("FAIL add_result: got %0d, required 46", result);
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL add_valid_pulses: got %0d, required 1", pulses);
    end
    got = echo_str();
    tests++;
    if (got != "12+34=") begin
      fails++; $display("FAIL add_echo: got \"%s\", required \"12+34=\"", got);
    end
  endtask

  task automatic test_sub_chain();
    pulses = 0;
    press(4'd5); press(4'd11); press(4'd9); press(4'd15);
    tests++;
    if (result !== 16'hFFFC || pulses != 1) begin
      fails++; $display("FAIL sub_result: got %h pulses %0d, required fffc pulses 1", result, pulses);
    end
    press(4'd10); press(4'd1); press(4'd15);
    tests++;
    if (result !== 16'hFFFD || pulses != 2 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL chain_result: got %h pulses %0d ovf %b, required fffd pulses 2 ovf 0",
               result, pulses, overflow);
    end
  endtask

  task automatic test_digit_limit();
    string got;
    echo_q.delete();
    for (int d = 1; d <= 5; d++) press(4'(d));
    tests++;
    if (entry !== 16'd1234) begin
      fails++; $display("FAIL digit_limit_entry: got %0d, required 1234", entry);
    end
    got = echo_str();
    tests++;
    if (got != "1234") begin
      fails++; $display("FAIL digit_limit_echo: got \"%s\", required \"1234\"", got);
    end
  endtask

  task automatic test_overflow();
    press(4'd14);
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 4; d++) press(4'd9);
      press(4'd10);
    end
    press(4'd15);
    tests++;
    if (result !== 16'h9C3C || overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_result: got %0d ovf %b, required -25540 ovf 1", result, overflow);
    end
    press(4'd7);
    tests++;
    if (overflow !== 1'b0 || entry !== 16'd7) begin
      fails++;
      $display("FAIL overflow_clear: got ovf %b entry %0d, required ovf 0 entry 7", overflow, entry);
    end
  endtask

  task automatic test_echo_backpressure();
    tx_ready = 1'b1;
    press(4'd14);
    tx_ready = 1'b0;
    press(4'd1); press(4'd2);
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h31 || entry !== 16'd12) begin
      fails++;
      $display("FAIL echo_hold: got valid %b data %h entry %0d, required 1/31/12",
               tx_valid, tx_data, entry);
    end
    press(4'd14);
    tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h43 || entry !== 16'd0) begin
      fails++;
      $display("FAIL echo_clear: got valid %b data %h entry %0d, required 1/43/0",
               tx_valid, tx_data, entry);
    end
    tx_ready = 1'b1;
    cycle();
    tx_ready = 1'b0;
    tests++;
    if (tx_valid !== 1'b0) begin
      fails++; $display("FAIL echo_drain: got valid %b, required 0", tx_valid);
    end
  endtask

  task automatic test_reset_mid();
    string got;
    tx_ready = 1'b0;
    press(4'd1); press(4'd2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    tests++;
    if ({entry, result, result_valid, overflow, tx_data, tx_valid} !== 43'd0) begin
      fails++;
      $display("FAIL reset_mid: entry=%0d result=%0d valid=%b ovf=%b tx=%h/%b, required all 0",
               entry, result, result_valid, overflow, tx_data, tx_valid);
    end
    tx_ready = 1'b1; echo_q.delete();
    key = 1'b1; value = 4'd3;
    repeat (20) cycle();
    key = 1'b0;
    repeat (4) cycle();
    got = echo_str();
    tests++;
    if (entry !== 16'd3 || got != "3") begin
      fails++; $display("FAIL long_hold: got entry %0d echo \"%s\", required 3 \"3\"", entry, got);
    end
  endtask

  function automatic logic [3:0] rand_code();
    int r;
    r = $urandom_range(0, 99);
    if (r < 60) return 4'($urandom_range(0, 9));
    if (r < 72) return 4'd10;
    if (r < 84) return 4'd11;
    if (r < 94) return 4'd15;
    if (r < 97) return 4'd14;
    return 4'($urandom_range(12, 13));
  endfunction

  task automatic test_random();
    int left = 1;
    for (int n = 0; n < 3000; n++) begin
      left--;
      if (left <= 0) begin
        if (key) begin
          key = 1'b0; left = $urandom_range(1, 4);
        end else begin
          key = 1'b1; value = rand_code(); left = $urandom_range(1, 6);
        end
      end else if (key && $urandom_range(0, 19) == 0) begin
        value = rand_code();
      end
      tx_ready = ($urandom_range(0, 9) < 7);
      cycle();
      tests++;
      if (entry !== 16'(m_entry) || result !== 16'(m_result) || result_valid !== m_valid ||
          overflow !== m_ovf || tx_valid !== m_txv || (m_txv && tx_data !== m_txd)) begin
        fails++;
        $display("FAIL random[%0d]: got entry=%0d res=%0d v=%b ovf=%b tx=%h/%b, required entry=%0d res=%0d v=%b ovf=%b tx=%h/%b",
                 n, entry, result, result_valid, overflow, tx_data, tx_valid,
                 m_entry, 16'(m_result), m_valid, m_ovf, m_txd, m_txv);
      end
    end
    key = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add_chain();
    test_sub_chain();
    test_digit_limit();
    test_overflow();
    test_echo_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
